averager_ctrl: RTL and testbench

AVERAGER_CTRL -- requirements
Module: averager_ctrl

---
 rtl/averager_ctrl_pkg.sv | 19 +
 rtl/averager_ctrl_skid.sv | 77 +++++++
 rtl/averager_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_averager_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/averager_ctrl_pkg.sv
// Shared definitions for the averager controller: FSM encoding, error codes
// and the number of cycles the averager is held in reset before acquisition.
package averager_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_ACQ  = 3'd2,
        ST_READ = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CFG     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam int ARM_CYCLES = 2;

endpackage

// File: rtl/averager_ctrl_skid.sv
// Two-entry readout buffer between the BRAM read port and the AXI-Stream
// output. Slot 0 drives the stream; slot 1 catches a word that arrives while
// slot 0 is stalled. The issuer upstream guarantees it never overfills.
module avg_readout_skid
    import averager_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_flush,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_last,
    output logic [1:0]            o_count,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic                  o_tlast
);

    logic                  r_vld0;
    logic                  r_vld1;
    logic [DATA_WIDTH-1:0] r_data0;
    logic [DATA_WIDTH-1:0] r_data1;
    logic                  r_last0;
    logic                  r_last1;

    logic w_pop;
    logic w_load0;
    logic w_wr1;

    assign w_pop   = r_vld0 & i_tready;
    // Slot 0 takes a new word whenever it is empty or its word is leaving.
    assign w_load0 = w_pop | ~r_vld0;
    // An incoming word lands in slot 1 if slot 0 stays put or slot 1 is moving down.
    assign w_wr1   = i_wr_en & (~w_load0 | r_vld1);

    assign o_count  = {1'b0, r_vld0} + {1'b0, r_vld1};
    assign o_tvalid = r_vld0;
    assign o_tdata  = r_data0;
    assign o_tlast  = r_vld0 & r_last0;

    // Occupancy flags: the only buffer state cleared by reset or flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld0 <= 1'b0;
            r_vld1 <= 1'b0;
        end else if (i_flush) begin
            r_vld0 <= 1'b0;
            r_vld1 <= 1'b0;
        end else if (w_load0) begin
            r_vld0 <= r_vld1 | i_wr_en;
            r_vld1 <= r_vld1 & i_wr_en;
        end else begin
            r_vld1 <= r_vld1 | i_wr_en;
        end
    end

    // Word storage; meaningless unless the matching valid flag is set.
    always_ff @(posedge clk) begin
        if (w_load0) begin
            if (r_vld1) begin
                r_data0 <= r_data1;
                r_last0 <= r_last1;
            end else begin
                r_data0 <= i_wr_data;
                r_last0 <= i_wr_last;
            end
        end
        if (w_wr1) begin
            r_data1 <= i_wr_data;
            r_last1 <= i_wr_last;
        end
    end

endmodule

// File: rtl/averager_ctrl.sv
// Controller around a hardware trace averager: arms it, gates triggers during
// acquisition with an optional per-trigger timeout, then streams the averaged
// trace out of BRAM over AXI-Stream at one word per cycle.
module averager_ctrl
    import averager_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [15:0]           nsamples_cfg,
    input  logic [31:0]           naverages_cfg,
    input  logic [31:0]           timeout_cfg,
    input  logic                  trig_in,
    input  logic                  avg_finished,
    output logic                  avg_reset,
    output logic                  avg_trig,
    output logic [15:0]           avg_nsamples,
    output logic [31:0]           avg_naverages,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_en,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            error
);

    localparam logic [1:0] ARM_LAST = 2'(ARM_CYCLES - 1);

    state_t                r_state;
    logic [15:0]           r_nsamples;
    logic [31:0]           r_naverages;
    logic [1:0]            r_arm_cnt;
    logic [31:0]           r_to_cnt;
    logic                  r_trig_d;
    logic [ADDR_WIDTH-1:0] r_rd_idx;
    logic                  r_avg_reset;
    logic                  r_busy;
    logic                  r_done;
    logic [1:0]            r_error;
    logic                  r_vld_p1;
    logic                  r_last_p1;

    state_t                w_state_nxt;
    logic                  w_cfg_ok;
    logic                  w_trig_rise;
    logic [31:0]           w_to_next;
    logic                  w_timeout;
    logic [ADDR_WIDTH-1:0] w_n_ext;
    logic                  w_issue;
    logic                  w_issue_last;
    logic                  w_pop;
    logic                  w_pop_last;
    logic [1:0]            w_buf_cnt;
    logic [2:0]            w_occ;

    assign w_cfg_ok     = (nsamples_cfg != 16'd0) && (naverages_cfg != 32'd0);
    assign w_trig_rise  = trig_in & ~r_trig_d;
    assign w_to_next    = r_to_cnt + 32'd1;
    assign w_timeout    = !w_trig_rise && (timeout_cfg != 32'd0) && (w_to_next == timeout_cfg);
    assign w_n_ext      = ADDR_WIDTH'(r_nsamples);
    assign w_pop        = m_axis_tvalid & m_axis_tready;
    assign w_pop_last   = w_pop & m_axis_tlast;

    // Words that will still occupy the buffer after this cycle's handshake,
    // plus the read already in flight; a new read may only be issued when that
    // leaves room for it even if the consumer stalls from here on.
    assign w_occ        = {2'b00, r_vld_p1} + {1'b0, w_buf_cnt} - {2'b00, w_pop};
    assign w_issue      = (r_state == ST_READ) && !abort && (r_rd_idx < w_n_ext) && (w_occ < 3'd2);
    assign w_issue_last = (r_rd_idx + ADDR_WIDTH'(1)) == w_n_ext;

    assign bram_en       = w_issue;
    assign bram_addr     = r_rd_idx << 2;
    assign avg_trig      = (r_state == ST_ACQ) & trig_in;
    assign avg_reset     = r_avg_reset;
    assign avg_nsamples  = r_nsamples;
    assign avg_naverages = r_naverages;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;

    // Next-state decode; abort overrides everything, including a same-cycle start.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: if (start && w_cfg_ok) w_state_nxt = ST_ARM;
                ST_ARM:           if (r_arm_cnt == ARM_LAST) w_state_nxt = ST_ACQ;
                ST_ACQ: begin
                    if (avg_finished)   w_state_nxt = ST_READ;
                    else if (w_timeout) w_state_nxt = ST_IDLE;
                end
                ST_READ:          if (w_pop_last) w_state_nxt = ST_DONE;
                default:          w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Control FSM: state, latched config, counters and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_nsamples  <= 16'd0;
            r_naverages <= 32'd0;
            r_arm_cnt   <= 2'd0;
            r_to_cnt    <= 32'd0;
            r_trig_d    <= 1'b0;
            r_rd_idx    <= '0;
            r_avg_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= ERR_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_avg_reset <= !((w_state_nxt == ST_ACQ) || (w_state_nxt == ST_READ));
            r_busy      <= (w_state_nxt == ST_ARM) || (w_state_nxt == ST_ACQ) ||
                           (w_state_nxt == ST_READ);
            r_trig_d    <= trig_in;
            if (!abort) begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            if (!w_cfg_ok) begin
                                r_error <= ERR_CFG;
                            end else begin
                                r_nsamples  <= nsamples_cfg;
                                r_naverages <= naverages_cfg;
                                r_error     <= ERR_NONE;
                                r_done      <= 1'b0;
                                r_arm_cnt   <= 2'd0;
                                r_rd_idx    <= '0;
                            end
                        end
                    end
                    ST_ARM: begin
                        r_arm_cnt <= r_arm_cnt + 2'd1;
                        r_to_cnt  <= 32'd0;
                    end
                    ST_ACQ: begin
                        if (w_timeout && !avg_finished) r_error <= ERR_TIMEOUT;
                        r_to_cnt <= w_trig_rise ? 32'd0 : w_to_next;
                    end
                    ST_READ: begin
                        if (w_issue)    r_rd_idx <= r_rd_idx + ADDR_WIDTH'(1);
                        if (w_pop_last) r_done   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read-issue stage -> BRAM data stage: tags the word returning next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
        end else begin
            r_vld_p1  <= w_issue;
            r_last_p1 <= w_issue_last;
        end
    end

    avg_readout_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .i_flush   (abort),
        .i_wr_en   (r_vld_p1),
        .i_wr_data (bram_rdata),
        .i_wr_last (r_last_p1),
        .o_count   (w_buf_cnt),
        .o_tdata   (m_axis_tdata),
        .o_tvalid  (m_axis_tvalid),
        .i_tready  (m_axis_tready),
        .o_tlast   (m_axis_tlast)
    );

endmodule

// File: tb/tb_averager_ctrl.sv
// Bench for averager_ctrl: BRAM and averager models, a stream monitor, a
// table of complete runs and hand-written corner-case sequences.
module tb_averager_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [15:0]   nsamples_cfg;
    logic [31:0]   naverages_cfg;
    logic [31:0]   timeout_cfg;
    logic          trig_in;
    logic          avg_finished;
    logic          avg_reset;
    logic          avg_trig;
    logic [15:0]   avg_nsamples;
    logic [31:0]   avg_naverages;
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic [DW-1:0] bram_rdata;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          busy;
    logic          done;
    logic [1:0]    error;

    int n_checks = 0;
    int n_errors = 0;

    averager_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .nsamples_cfg  (nsamples_cfg),
        .naverages_cfg (naverages_cfg),
        .timeout_cfg   (timeout_cfg),
        .trig_in       (trig_in),
        .avg_finished  (avg_finished),
        .avg_reset     (avg_reset),
        .avg_trig      (avg_trig),
        .avg_nsamples  (avg_nsamples),
        .avg_naverages (avg_naverages),
        .bram_addr     (bram_addr),
        .bram_en       (bram_en),
        .bram_rdata    (bram_rdata),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    // BRAM model: word at index i holds A000_0000 + i, one-cycle read latency.
    always @(posedge clk) begin
        if (bram_en) bram_rdata <= 32'hA000_0000 + (bram_addr >> 2);
    end

    // Averager model: counts gated trigger pulses, finishes after naverages.
    logic [31:0] m_trigs;
    logic        m_trig_prev;
    always @(posedge clk) begin
        if (avg_reset) m_trigs <= 32'd0;
        else if (avg_trig && !m_trig_prev) m_trigs <= m_trigs + 32'd1;
        m_trig_prev <= avg_trig;
    end
    assign avg_finished = !avg_reset && (avg_naverages != 32'd0) && (m_trigs >= avg_naverages);

    // Stream / BRAM monitor, sampled on the falling edge.
    logic [31:0] beat_data[$];
    logic        beat_last[$];
    int          beat_cyc[$];
    logic [31:0] addr_q[$];
    int          en_cyc[$];
    int          cyc = 0;
    int          stall_viol;
    int          arm_cyc;
    bit          busy_seen;
    bit          rst_low_seen;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (m_axis_tvalid && m_axis_tready) begin
            beat_data.push_back(m_axis_tdata);
            beat_last.push_back(m_axis_tlast);
            beat_cyc.push_back(cyc);
        end
        if (bram_en) begin
            addr_q.push_back(bram_addr);
            en_cyc.push_back(cyc);
        end
        if (prev_stall && (!m_axis_tvalid || m_axis_tdata != prev_data || m_axis_tlast != prev_last))
            stall_viol = stall_viol + 1;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        if (busy && avg_reset) arm_cyc = arm_cyc + 1;
        if (busy) busy_seen = 1'b1;
        if (!avg_reset) rst_low_seen = 1'b1;
    end

    typedef struct {
        logic [15:0] ns;
        logic [31:0] na;
        bit          toggle;
        logic [1:0]  exp_err;
        bit          exp_done;
        int          exp_beats;
        bit          chk_tput;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        beat_data.delete();
        beat_last.delete();
        beat_cyc.delete();
        addr_q.delete();
        en_cyc.delete();
        stall_viol   = 0;
        arm_cyc      = 0;
        busy_seen    = 1'b0;
        rst_low_seen = 1'b0;
        prev_stall   = 1'b0;
    endtask

    task automatic do_reset();
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic start_run(input logic [15:0] ns, input logic [31:0] na, input logic [31:0] to);
        nsamples_cfg  = ns;
        naverages_cfg = na;
        timeout_cfg   = to;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_case(input vec_t v, input int idx);
        bit fin;
        do_reset();
        clear_mon();
        start_run(v.ns, v.na, 32'd0);
        fin = 1'b0;
        for (int c = 0; c < 600 && !fin; c++) begin
            trig_in       = (c % 6 == 1);
            m_axis_tready = v.toggle ? (c % 2 == 0) : 1'b1;
            tick();
            if (done || error != 2'b00) fin = 1'b1;
        end
        trig_in       = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        tick();
        tick();
        chk($sformatf("row%0d_finished", idx), 32'(fin), 32'd1);
        chk($sformatf("row%0d_error", idx), 32'(error), 32'(v.exp_err));
        chk($sformatf("row%0d_done", idx), 32'(done), 32'(v.exp_done));
        chk($sformatf("row%0d_busy_end", idx), 32'(busy), 32'd0);
        chk($sformatf("row%0d_busy_seen", idx), 32'(busy_seen), 32'(v.exp_done));
        chk($sformatf("row%0d_avg_reset_low_seen", idx), 32'(rst_low_seen), 32'(v.exp_done));
        chk($sformatf("row%0d_arm_cycles", idx), 32'(arm_cyc), v.exp_done ? 32'd2 : 32'd0);
        chk($sformatf("row%0d_latched_ns", idx), 32'(avg_nsamples), v.exp_done ? 32'(v.ns) : 32'd0);
        chk($sformatf("row%0d_beats", idx), 32'(beat_data.size()), 32'(v.exp_beats));
        chk($sformatf("row%0d_reads", idx), 32'(addr_q.size()), 32'(v.exp_beats));
        chk($sformatf("row%0d_stall_stable", idx), 32'(stall_viol), 32'd0);
        for (int i = 0; i < v.exp_beats && i < beat_data.size() && i < addr_q.size(); i++) begin
            chk($sformatf("row%0d_data%0d", idx, i), beat_data[i], 32'hA000_0000 + 32'(i));
            chk($sformatf("row%0d_last%0d", idx, i), 32'(beat_last[i]), 32'(i == v.exp_beats - 1));
            chk($sformatf("row%0d_addr%0d", idx, i), addr_q[i], 32'(4 * i));
        end
        if (v.chk_tput && beat_cyc.size() > 0 && en_cyc.size() > 0) begin
            chk($sformatf("row%0d_first_latency", idx), 32'(beat_cyc[0] - en_cyc[0]), 32'd2);
            for (int i = 1; i < beat_cyc.size(); i++)
                chk($sformatf("row%0d_beat_spacing%0d", idx, i), 32'(beat_cyc[i] - beat_cyc[0]), 32'(i));
        end
    endtask

    initial begin
        vec_t vecs[5];
        int   n;
        int   seen;
        vecs[0] = '{16'd4, 32'd3, 1'b0, 2'b00, 1'b1, 4, 1'b1};
        vecs[1] = '{16'd0, 32'd3, 1'b0, 2'b01, 1'b0, 0, 1'b0};
        vecs[2] = '{16'd5, 32'd0, 1'b0, 2'b01, 1'b0, 0, 1'b0};
        vecs[3] = '{16'd8, 32'd2, 1'b1, 2'b00, 1'b1, 8, 1'b0};
        vecs[4] = '{16'd1, 32'd1, 1'b0, 2'b00, 1'b1, 1, 1'b1};

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        nsamples_cfg  = 16'd0;
        naverages_cfg = 32'd0;
        timeout_cfg   = 32'd0;
        trig_in       = 1'b1;
        m_axis_tready = 1'b1;
        clear_mon();
        tick();
        tick();

        // Reset state, with the raw trigger held high.
        chk("rst_avg_reset", 32'(avg_reset), 32'd1);
        chk("rst_avg_trig", 32'(avg_trig), 32'd0);
        chk("rst_bram_en", 32'(bram_en), 32'd0);
        chk("rst_bram_addr", bram_addr, 32'd0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_nsamples", 32'(avg_nsamples), 32'd0);
        chk("rst_naverages", avg_naverages, 32'd0);
        reset   = 1'b0;
        trig_in = 1'b0;
        tick();

        for (int r = 0; r < 5; r++) run_case(vecs[r], r);

        // Trigger timeout after 100 cycles of ACQ.
        do_reset();
        clear_mon();
        trig_in = 1'b0;
        start_run(16'd4, 32'd3, 32'd100);
        for (int c = 0; c < 20 && avg_reset; c++) tick();
        chk("to_acq_entered", 32'(avg_reset), 32'd0);
        n = 0;
        for (int c = 0; c < 300 && busy; c++) begin
            tick();
            n = n + 1;
            if (n == 99) chk("to_no_error_at_99", 32'(error), 32'd0);
        end
        chk("to_cycles", 32'(n), 32'd100);
        chk("to_error", 32'(error), 32'h2);
        chk("to_avg_reset", 32'(avg_reset), 32'd1);
        chk("to_done", 32'(done), 32'd0);

        // Abort during READ after three beats.
        do_reset();
        clear_mon();
        m_axis_tready = 1'b1;
        start_run(16'd8, 32'd1, 32'd0);
        for (int c = 0; c < 200 && beat_data.size() < 3; c++) begin
            trig_in = (c % 6 == 1);
            tick();
        end
        trig_in = 1'b0;
        chk("ab_three_beats", 32'(beat_data.size()), 32'd3);
        abort = 1'b1;
        m_axis_tready = 1'b0;
        tick();
        abort = 1'b0;
        chk("ab_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_avg_reset", 32'(avg_reset), 32'd1);
        chk("ab_bram_en", 32'(bram_en), 32'd0);
        chk("ab_error", 32'(error), 32'd0);
        m_axis_tready = 1'b1;
        tick();
        chk("ab_tvalid_after", 32'(m_axis_tvalid), 32'd0);
        chk("ab_beats_total", 32'(beat_data.size()), 32'd3);

        // Abort and start together: abort wins.
        nsamples_cfg  = 16'd4;
        naverages_cfg = 32'd1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("as_busy", 32'(busy), 32'd0);
        chk("as_avg_reset", 32'(avg_reset), 32'd1);
        tick();
        chk("as_busy_later", 32'(busy), 32'd0);

        // Asynchronous reset between clock edges during ACQ.
        do_reset();
        clear_mon();
        start_run(16'd4, 32'd3, 32'd0);
        for (int c = 0; c < 20 && avg_reset; c++) tick();
        chk("ar_acq_entered", 32'(avg_reset), 32'd0);
        trig_in = 1'b1;
        #1;
        chk("ar_trig_gated_on", 32'(avg_trig), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_avg_reset", 32'(avg_reset), 32'd1);
        chk("ar_avg_trig", 32'(avg_trig), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("ar_nsamples", 32'(avg_nsamples), 32'd0);
        tick();
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            trig_in = (c % 2 == 0);
            #1;
            if (avg_trig) seen = seen + 1;
            tick();
        end
        chk("ar_no_trig_after", 32'(seen), 32'd0);
        chk("ar_busy_after", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
